// File: rtl/wb_master_ctrl_if.sv
// Bundles the command, response and Wishbone-style bus channels of wb_master_ctrl.
// The master modport is the controller's view; slave is the view of everything around it.
interface wb_master_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_we;

  logic              we;
  logic              strb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  logic              busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, rdata, ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we, we, strb, addr, wdata, busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, rdata, ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we, we, strb, addr, wdata, busy
  );
endinterface

// File: rtl/wb_master_ctrl.sv
// Bus master: queues read/write commands in a small FIFO, runs one strobe/ack
// transaction at a time with a timeout, and returns one response per command.
module wb_master_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst_n,
  wb_master_ctrl_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  logic              strb_q, strb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = bus.cmd_valid && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push};
  assign rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  always_comb begin
    state_d     = state_q;
    strb_d      = strb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          {we_d, addr_d, wdata_d} = head;
          strb_d  = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack on the final timeout cycle still completes the transfer normally.
        if (bus.ack) begin
          strb_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_we_d    = we_q;
          rsp_rdata_d = we_q ? '0 : bus.rdata;
          state_d     = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          strb_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_we_d    = we_q;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      strb_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      strb_q      <= strb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.strb      = strb_q;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_wb_master_ctrl.sv
// Scoreboard bench for wb_master_ctrl: a memory-backed slave model with programmed
// ack latencies, a response monitor, and directed plus random command streams.
module tb_wb_master_ctrl;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int NEVER      = 255;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
  } plan_t;

  typedef struct {
    logic       we;
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  plan_t plan_q[$];
  rsp_t  exp_q[$];
  logic [7:0] ref_mem   [256];
  logic [7:0] slave_mem [256];

  wb_master_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wb_master_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: acks after the planned number of strobe cycles, NEVER means no ack.
  plan_t cur;
  bit    active   = 0;
  bit    cur_ok   = 0;
  int    hi_cnt   = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active  = 0;
      bus.ack = 1'b0;
    end else if (bus.strb) begin
      if (!active) begin
        active = 1;
        hi_cnt = 0;
        cur_ok = (plan_q.size() != 0);
        if (!cur_ok) check("unexpected strb", bus.strb, 0);
        else begin
          cur = plan_q.pop_front();
          check("bus we", bus.we, cur.we);
          check("bus addr", bus.addr, cur.addr);
          check("bus wdata", bus.wdata, cur.wdata);
        end
      end else if (cur_ok) begin
        check("bus hold", {bus.we, bus.addr, bus.wdata}, {cur.we, cur.addr, cur.wdata});
      end
      hi_cnt++;
      if (cur_ok && cur.lat == hi_cnt - 1) begin
        bus.ack   = 1'b1;
        bus.rdata = slave_mem[cur.addr];
        if (cur.we) slave_mem[cur.addr] = cur.wdata;
      end else begin
        bus.ack   = 1'b0;
        bus.rdata = 8'($urandom);
      end
    end else begin
      if (active && cur_ok)
        check("strb cycles", hi_cnt, (cur.lat < TIMEOUT) ? cur.lat + 1 : TIMEOUT);
      active    = 0;
      bus.ack   = ($urandom_range(3) == 0);  // stray acks outside a request
      bus.rdata = 8'($urandom);
    end
  end

  // Response monitor and rsp_ready driver.
  rsp_t held;
  bit   seen = 0;
  int   rsp_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else begin
      if (bus.rsp_valid && bus.strb) check("rsp_valid with strb", bus.strb, 0);
      if (bus.rsp_valid) begin
        if (!seen) begin
          seen = 1;
          if (exp_q.size() == 0) begin
            check("unexpected rsp_valid", bus.rsp_valid, 0);
            held = '{we: bus.rsp_we, rdata: bus.rsp_rdata, err: bus.rsp_err};
          end else begin
            held = exp_q.pop_front();
            rsp_n++;
            $display("rsp %0d: we=%0d rdata=0x%02h err=%0d (exp we=%0d rdata=0x%02h err=%0d)",
                     rsp_n, bus.rsp_we, bus.rsp_rdata, bus.rsp_err, held.we, held.rdata, held.err);
            check("rsp_we", bus.rsp_we, held.we);
            check("rsp_rdata", bus.rsp_rdata, held.rdata);
            check("rsp_err", bus.rsp_err, held.err);
          end
        end else begin
          check("rsp hold", {bus.rsp_we, bus.rsp_rdata, bus.rsp_err}, {held.we, held.rdata, held.err});
        end
      end else if (seen) begin
        check("rsp after fall", {bus.rsp_rdata, bus.rsp_err}, {held.rdata, held.err});
        seen = 0;
      end
    end
    bus.rsp_ready = (ready_mode == 2) ? ($urandom_range(1) == 1) : (ready_mode == 1);
  end

  // Offers one command from a negedge; records the expected outcome when it is accepted.
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d,
                      input int lat, output int waited);
    rsp_t r;
    waited        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) check("cmd accept timeout", bus.cmd_ready, 1);
    else begin
      plan_q.push_back('{we: we, addr: a, wdata: d, lat: lat});
      r.we    = we;
      r.err   = (lat >= TIMEOUT);
      r.rdata = (we || lat >= TIMEOUT) ? 8'h00 : ref_mem[a];
      if (we && lat < TIMEOUT) ref_mem[a] = d;
      exp_q.push_back(r);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, " drained"}, (n < 2000), 1);
    check({name, " busy"}, bus.busy, 0);
  endtask

  initial begin
    int w;
    int n;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 8'(i) ^ 8'h5A;
      slave_mem[i] = 8'(i) ^ 8'h5A;
    end

    repeat (3) @(negedge clk);
    check("reset strb", bus.strb, 0);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset cmd_ready", bus.cmd_ready, 1);
    check("reset rsp_err", bus.rsp_err, 0);
    check("reset rsp_rdata", bus.rsp_rdata, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle strb", bus.strb, 0);
    check("idle busy", bus.busy, 0);

    send(1'b1, 8'h05, 8'hA5, 0, w);
    send(1'b0, 8'h05, 8'h3C, 1, w);
    drain("write_read");

    ready_mode = 0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      send(i[0], 8'(i), 8'(8'h10 + i), 0, w);
      check("fifo fill no wait", w, 0);
    end
    check("fifo full cmd_ready", bus.cmd_ready, 0);
    ready_mode = 2;
    drain("fifo_full");

    send(1'b0, 8'h33, 8'h00, NEVER, w);
    send(1'b1, 8'h34, 8'h77, 0, w);
    send(1'b0, 8'h34, 8'h00, TIMEOUT - 1, w);
    drain("timeout");

    ready_mode = 0;
    @(negedge clk);
    send(1'b1, 8'h40, 8'h9C, 0, w);
    send(1'b0, 8'h40, 8'h00, 2, w);
    repeat (10) @(negedge clk);
    check("backpressure rsp_valid", bus.rsp_valid, 1);
    check("backpressure strb", bus.strb, 0);
    ready_mode = 2;
    drain("backpressure");

    for (int i = 0; i < 200; i++) begin
      int lat;
      repeat ($urandom_range(2)) @(negedge clk);
      lat = ($urandom_range(9) == 0) ? NEVER : int'($urandom_range(3));
      send(1'($urandom), 8'($urandom_range(15)), 8'($urandom), lat, w);
    end
    drain("random");

    ready_mode = 1;
    for (int i = 0; i < 3; i++) send(1'b0, 8'(8'h60 + i), 8'h00, NEVER, w);
    n = 0;
    while (!bus.strb && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid reset strb seen", bus.strb, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    plan_q.delete();
    exp_q.delete();
    #1;
    check("mid reset strb", bus.strb, 0);
    check("mid reset busy", bus.busy, 0);
    check("mid reset rsp_valid", bus.rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post reset strb", bus.strb, 0);
    check("post reset rsp_valid", bus.rsp_valid, 0);
    check("post reset busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
